// File: rtl/bitbang_cfg_rx.sv
// bitbang_cfg_rx: receiver for the two-wire bit-bang configuration port.
// Each s_clk rising edge shifts one data bit and each falling edge shifts
// one control bit, both MSB-first. When the last 16 control bits equal
// CTRL_WORD, the 32-bit data word is presented with a one-cycle WriteStrobe.
// s_clk/s_data are asynchronous and are oversampled on CLK.
// Optional feature: define BITBANG_RX_WORDCOUNT_EN to add the WordCount
// output, a 16-bit wrapping count of accepted words.
module bitbang_cfg_rx #(
    parameter int          SYNC_STAGES = 2,        // synchronizer depth, >= 2
    parameter logic [15:0] CTRL_WORD   = 16'hFAB1, // must be non-zero
    parameter int          TIMEOUT     = 1024,
    parameter int          ACTIVE_HOLD = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_clk,
    input  logic        s_data,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic        FrameErr
`ifdef BITBANG_RX_WORDCOUNT_EN
    ,
    output logic [15:0] WordCount
`endif
);

    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(ACTIVE_HOLD + 1);

    typedef enum logic {
        WAIT_RISE = 1'b0,
        WAIT_FALL = 1'b1
    } state_t;

    state_t state, state_next;

    // Synchronizer chains; both pins use the same depth so data stays
    // aligned with the synced clock.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   sclk_prev;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   rise;
    logic                   fall;
    logic                   rise_acc;
    logic                   fall_acc;

    // Shift state. Only the low 16 control bits take part in matching,
    // so the control register is kept at that width.
    logic [31:0]            data_sr;
    logic [15:0]            ctrl_sr;
    logic [4:0]             bitcnt;
    logic [TO_W-1:0]        to_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   timeout_hit;
    logic                   match;

    // Saturating increment for the idle counter: it parks at TIMEOUT.
    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_W'(TIMEOUT)) ? v : v + TO_W'(1);
    endfunction

    // Saturating decrement for the activity hold counter: it parks at 0.
    function automatic logic [HOLD_W-1:0] hold_sat_dec(input logic [HOLD_W-1:0] v);
        return (v == '0) ? v : v - HOLD_W'(1);
    endfunction

    assign sync_clk  = sclk_sync[SYNC_STAGES-1];
    assign sync_data = sdata_sync[SYNC_STAGES-1];
    assign rise      = sync_clk & ~sclk_prev;
    assign fall      = ~sync_clk & sclk_prev;
    assign rise_acc  = (state == WAIT_RISE) & rise;
    assign fall_acc  = (state == WAIT_FALL) & fall;

    // An edge in the same cycle always wins over the timeout, so the first
    // rise after a long idle period is never discarded.
    assign timeout_hit = ~(rise | fall) & (to_cnt == TO_W'(TIMEOUT));

    // Evaluated on the registered control word, one cycle after the fall
    // that completed it; clearing ctrl_sr on a hit keeps this single-shot.
    assign match = (ctrl_sr == CTRL_WORD);

    // ---- stage: pin synchronization and edge history ----
    // Shift both pins through their synchronizers and remember last s_clk.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], s_clk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], s_data};
            sclk_prev  <= sync_clk;
        end
    end

    // ---- stage: slot FSM and shift registers ----
    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= WAIT_RISE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: alternate rise/fall; a fall while waiting for a rise
    // (s_clk high at reset release) is ignored.
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = WAIT_RISE;
        end else begin
            case (state)
                WAIT_RISE: if (rise) state_next = WAIT_FALL;
                WAIT_FALL: if (fall) state_next = WAIT_RISE;
                default:   state_next = WAIT_RISE;
            endcase
        end
    end

    // Shift data on rises and control on falls; timeout discards a partial word.
    always_ff @(posedge CLK) begin
        if (RST || timeout_hit) begin
            data_sr <= '0;
            ctrl_sr <= '0;
            bitcnt  <= '0;
        end else begin
            if (rise_acc) begin
                data_sr <= {data_sr[30:0], sync_data};
            end
            if (fall_acc) begin
                ctrl_sr <= {ctrl_sr[14:0], sync_data};
            end else if (match) begin
                ctrl_sr <= '0;
            end
            // A rise right after an accepted word is the first bit of the next.
            if (match) begin
                bitcnt <= rise_acc ? 5'd1 : 5'd0;
            end else if (rise_acc) begin
                bitcnt <= bitcnt + 5'd1;
            end
        end
    end

    // Idle counter: cleared by any s_clk edge, otherwise counts up to TIMEOUT.
    always_ff @(posedge CLK) begin
        if (RST || rise || fall) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_sat_inc(to_cnt);
        end
    end

    // ---- stage: word output, activity and error flags ----
    // Present the accepted word with a single-cycle strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WriteData   <= '0;
            WriteStrobe <= 1'b0;
        end else begin
            WriteStrobe <= match;
            if (match) begin
                WriteData <= data_sr;
            end
        end
    end

    // Stretch ComActive for ACTIVE_HOLD cycles after each accepted word;
    // it drops one cycle after the counter has reached zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt  <= '0;
            ComActive <= 1'b0;
        end else if (match) begin
            hold_cnt  <= HOLD_W'(ACTIVE_HOLD);
            ComActive <= 1'b1;
        end else begin
            hold_cnt  <= hold_sat_dec(hold_cnt);
            ComActive <= (hold_cnt != '0);
        end
    end

    // Sticky framing error: the link went idle part-way through a word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FrameErr <= 1'b0;
        end else if (timeout_hit && (bitcnt != 5'd0)) begin
            FrameErr <= 1'b1;
        end
    end

`ifdef BITBANG_RX_WORDCOUNT_EN
    // Count accepted words; the new count is visible alongside WriteStrobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WordCount <= '0;
        end else if (match) begin
            WordCount <= WordCount + 16'd1;
        end
    end
`else
    // No accepted-word counter in this build.
`endif

endmodule

// File: tb/tb_bitbang_cfg_rx.sv
// Testbench for bitbang_cfg_rx: table-driven word vectors with a strobe
// scoreboard, plus hand-written timeout, mid-word reset and hold sequences.
// Define BITBANG_RX_WORDCOUNT_EN to also check the WordCount output.
module tb_bitbang_cfg_rx;

    localparam int TIMEOUT     = 1024;
    localparam int ACTIVE_HOLD = 4096;
    localparam int LATENCY     = 4;     // SYNC_STAGES + 2

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        s_clk = 1'b0;
    logic        s_data = 1'b0;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic        FrameErr;
`ifdef BITBANG_RX_WORDCOUNT_EN
    logic [15:0] WordCount;
    int          wc_exp = 0;
`endif

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int strobes  = 0;
    int fall_cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] data;
        logic [31:0] ctrl;
        int          junk;
        bit          strobe;
        logic [31:0] exp_wd;
    } vec_t;
    vec_t vecs[7];

    bitbang_cfg_rx #(
        .SYNC_STAGES (2),
        .CTRL_WORD   (16'hFAB1),
        .TIMEOUT     (TIMEOUT),
        .ACTIVE_HOLD (ACTIVE_HOLD)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_clk       (s_clk),
        .s_data      (s_data),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .ComActive   (ComActive),
        .FrameErr    (FrameErr)
`ifdef BITBANG_RX_WORDCOUNT_EN
        ,
        .WordCount   (WordCount)
`endif
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One bit slot: data set, rise, control set, fall; every phase one CLK.
    task automatic send_slot(input logic d, input logic c);
        step(); s_data = d;
        step(); s_clk  = 1'b1;
        step(); s_data = c;
        step(); s_clk  = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [31:0] c, input int junk,
                             input bit expect_strobe, input logic [31:0] exp_d);
        exp_t e;
        for (int j = 0; j < junk; j++) send_slot(1'($urandom_range(1, 0)), 1'b0);
        for (int b = 31; b >= 0; b--) send_slot(d[b], c[b]);
        if (expect_strobe) begin
            e.data = exp_d;
            e.due  = fall_cyc + LATENCY;
            sb.push_back(e);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest pending word, on time.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0 && cyc > sb[0].due) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_missing: none by cycle %0d, expected at cycle %0d", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (WriteStrobe === 1'b1) begin
            strobes++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe_unexpected: WriteStrobe=1 with data %h at cycle %0d, expected none",
                         WriteData, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_data", WriteData, e.data);
                check("strobe_cycle", cyc, e.due);
            end
            check("comactive_on_strobe", 32'(ComActive), 32'd1);
`ifdef BITBANG_RX_WORDCOUNT_EN
            wc_exp++;
            check("wordcount", 32'(WordCount), 32'(wc_exp));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int s_cyc;

        vecs[0] = '{32'h12345678, 32'h0000FAB0, 0, 1'b0, 32'h00000000};
        vecs[1] = '{32'hDEADBEEF, 32'h0000FAB1, 0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{32'hCAFEF00D, 32'h0000FAB1, 5, 1'b1, 32'hCAFEF00D};
        vecs[3] = '{32'h00000001, 32'h0000FAB1, 0, 1'b1, 32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 32'h0000FAB1, 0, 1'b1, 32'hFFFFFFFF};
        vecs[5] = '{32'h80000000, 32'hFFFFFAB1, 0, 1'b1, 32'h80000000};
        vecs[6] = '{32'h55AA33CC, 32'h0000FAB3, 0, 1'b0, 32'h80000000};

        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        step();
        check("rst_writedata", WriteData, 32'h0);
        check("rst_strobe", 32'(WriteStrobe), 32'd0);
        check("rst_comactive", 32'(ComActive), 32'd0);
        check("rst_frameerr", 32'(FrameErr), 32'd0);
`ifdef BITBANG_RX_WORDCOUNT_EN
        check("rst_wordcount", 32'(WordCount), 32'd0);
`endif

        for (int i = 0; i < 7; i++) begin
            n0 = strobes;
            send_word(vecs[i].data, vecs[i].ctrl, vecs[i].junk, vecs[i].strobe, vecs[i].data);
            repeat (12) step();
            check($sformatf("vec%0d_strobes", i), 32'(strobes - n0), vecs[i].strobe ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_writedata", i), WriteData, vecs[i].exp_wd);
            check($sformatf("vec%0d_frameerr", i), 32'(FrameErr), 32'd0);
        end

        // Timeout with a partial word pending.
        n0 = strobes;
        for (int j = 0; j < 10; j++) send_slot(1'($urandom_range(1, 0)), 1'b0);
        repeat (TIMEOUT + 5) step();
        check("timeout_frameerr", 32'(FrameErr), 32'd1);
        check("timeout_no_strobe", 32'(strobes - n0), 32'd0);
        send_word(32'h0F0F1234, 32'h0000FAB1, 0, 1'b1, 32'h0F0F1234);
        repeat (12) step();
        check("after_timeout_writedata", WriteData, 32'h0F0F1234);
        check("after_timeout_strobes", 32'(strobes - n0), 32'd1);
        check("frameerr_sticky", 32'(FrameErr), 32'd1);

        // Reset in the middle of a word.
        for (int j = 0; j < 20; j++) send_slot(1'($urandom_range(1, 0)), 1'b0);
        RST = 1'b1;
        step();
        RST = 1'b0;
`ifdef BITBANG_RX_WORDCOUNT_EN
        wc_exp = 0;
`endif
        step();
        check("midrst_frameerr", 32'(FrameErr), 32'd0);
        check("midrst_writedata", WriteData, 32'h0);
        check("midrst_comactive", 32'(ComActive), 32'd0);
        n0 = strobes;
        send_word(32'hA5A5A5A5, 32'h0000FAB1, 0, 1'b1, 32'hA5A5A5A5);
        s_cyc = fall_cyc + LATENCY;
        repeat (12) step();
        check("midrst_strobes", 32'(strobes - n0), 32'd1);
        check("midrst_word", WriteData, 32'hA5A5A5A5);
        check("midrst_frameerr_after", 32'(FrameErr), 32'd0);

        // ComActive hold window after the last accepted word.
        while (cyc < s_cyc + ACTIVE_HOLD) step();
        check("hold_last_high", 32'(ComActive), 32'd1);
        step();
        check("hold_dropped", 32'(ComActive), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitbang_cfg_rx.md
Name: bitbang_cfg_rx

Overview:
- Fabric-side receiver for the two-wire bit-bang configuration port (s_clk, s_data). The bench-side transmitter drives this port.
- Each bit slot carries one data bit, sampled at the s_clk rising edge, and one control bit, sampled at the s_clk falling edge. Both are shifted in MSB-first.
- When the control shift register matches the sync word (default 0xFAB1), the block emits the 32-bit data word as a one-cycle write strobe to the configuration frame logic.
- Runs on the fabric CLK domain; s_clk/s_data are asynchronous and oversampled.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for s_clk and s_data (min 2)
- CTRL_WORD, 16'hFAB1, control pattern that validates a data word
- TIMEOUT, 1024, CLK cycles with no s_clk edge before partial shift state is discarded
- ACTIVE_HOLD, 4096, CLK cycles ComActive stays high after the last accepted word

Ports:
- CLK  in  1  system clock; all logic is on its rising edge
- RST  in  1  synchronous, active-high reset
- s_clk  in  1  async bit-bang clock
- s_data  in  1  async bit-bang data/control
- WriteData  out  32  last accepted data word
- WriteStrobe  out  1  one-cycle pulse; WriteData is valid in this cycle
- ComActive  out  1  high while the link is active (stretched)
- FrameErr  out  1  sticky; set on timeout with a partial word; cleared by RST only

Behaviour:
- Reset values: WriteData=0, WriteStrobe=0, ComActive=0, FrameErr=0. Shift registers, bit counter and timeout counter are cleared. FSM goes to WAIT_RISE. Synchronizers reset to 0.
- Synchronization: s_clk and s_data go through identical SYNC_STAGES-deep flop chains. sclk_prev holds the last synced s_clk value. Data is always sampled from the same stage as the synced clock.
- Rise = sync_clk & ~sclk_prev. Fall = ~sync_clk & sclk_prev.
- Sender requirement: s_data stable ≥1 CLK cycle before and ≥1 CLK cycle after each s_clk edge. The s_clk high and low phases must each last ≥1 CLK cycle.
- FSM WAIT_RISE:
  - On rise: data_sr <= {data_sr[30:0], sync_data}; bitcnt++ (mod 32); go to WAIT_FALL.
  - A fall here is impossible after a clean reset. If one is seen anyway (s_clk high at reset release), ignore it.
- FSM WAIT_FALL:
  - On fall: ctrl_sr <= {ctrl_sr[30:0], sync_data}; go to WAIT_RISE.
  - Match check uses the new ctrl_sr value: if ctrl_sr[15:0]==CTRL_WORD, then in the next cycle WriteData <= data_sr, WriteStrobe=1 for exactly one cycle, ctrl_sr <= 0, bitcnt <= 0, ComActive <= 1, and the hold counter is loaded with ACTIVE_HOLD.
- Alignment: matching is on the control pattern, not on bitcnt. The receiver therefore self-aligns after junk bits. bitcnt is used only for timeout/error classification.
- Latency: WriteStrobe is asserted SYNC_STAGES+2 CLK cycles after the s_clk pin falls on the 32nd bit (4 cycles with defaults).
- Timeout:
  - The counter increments every cycle with no rise/fall and resets on any edge.
  - When it reaches TIMEOUT: if bitcnt!=0, set FrameErr. In all cases clear data_sr, ctrl_sr and bitcnt, and force the FSM to WAIT_RISE.
  - The counter saturates at TIMEOUT (no wrap).
- ComActive: the hold counter decrements to 0, and ComActive drops the cycle after it reaches 0. A new accepted word reloads it, including mid-hold.
- Simultaneous events: a strobe and a timeout cannot coincide, because the strobe follows an edge. RST has priority over everything.
- RST asserted mid-word discards the partial word with no strobe. After RST, the first strobe needs a full fresh 32-bit slot sequence.
- An all-zero ctrl_sr never matches CTRL_WORD unless CTRL_WORD==0. Parameterizing CTRL_WORD=0 is illegal.

Optional Feature:
- Macro BITBANG_RX_WORDCOUNT_EN.
- Defined: adds output port WordCount [15:0], reset 0. It increments in the same cycle WriteStrobe is high and wraps 0xFFFF→0x0000.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Clean word: RST 3 cycles, then bit-bang data 0xDEADBEEF / ctrl 0x0000FAB1 at 1 CLK per phase -> exactly one WriteStrobe with WriteData=0xDEADBEEF, 4 CLK after the last s_clk fall; ComActive=1.
- Bad ctrl: data 0x12345678 / ctrl 0x0000FAB0 -> no WriteStrobe; WriteData stays 0; FrameErr=0.
- Misalignment: 5 junk bit slots, then a full 0xCAFEF00D/0xFAB1 slot sequence -> one strobe with WriteData=0xCAFEF00D (the data register holds the last 32 rise bits).
- Timeout: send 10 bit slots, then idle TIMEOUT+5 cycles -> FrameErr=1, no strobe. A following clean word is accepted correctly.
- Reset mid-word: RST pulse after 20 bit slots, then 0xA5A5A5A5/0xFAB1 -> one strobe with 0xA5A5A5A5; FrameErr=0. ComActive falls ACTIVE_HOLD+1 cycles after the strobe.
- With BITBANG_RX_WORDCOUNT_EN: 3 back-to-back valid words -> WordCount = 1, 2, 3, each incrementing coincident with its strobe.
